cla_mul_seq: RTL

Iterative shift-add multiplier sequencer built around one shared WIDTH-bit carry-lookahead add/sub datapath. Accepts an operand pair over a valid/ready handshake and runs one add-and-shift step per clock for WIDTH clocks. Returns a 2*WIDTH-bit product over a valid/ready handshake. Sits beside the CLA adder in the arithmetic unit; it is the only driver of that adder's A, B and AddSub inputs.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_addsub.sv | 50 +++++
 rtl/cla_mul_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencer and its CLA datapath.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CLA_W = 8;

    // Smallest r with 2**r >= value; sizes the step counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_addsub.sv
// Combinational WIDTH-bit carry-lookahead adder/subtractor: R = A + B (AddSub=0) or A - B (AddSub=1).
module cla_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             AddSub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             OVR
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             cin;
    logic             term;

    assign cin   = AddSub;
    assign b_eff = B ^ {WIDTH{AddSub}};
    assign g     = A & b_eff;
    assign p     = A ^ b_eff;

    // Every carry is expanded as a flat sum of generate/propagate products.
    always_comb begin
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 1; i <= WIDTH; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
    end

    assign R    = p ^ c[WIDTH-1:0];
    assign Cout = c[WIDTH];
    assign OVR  = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/cla_mul_seq.sv
// Iterative shift-add multiplier on one shared CLA add/sub, one step per clock for WIDTH clocks.
// Build macro CLA_MUL_SIGNED_EN selects two's-complement operands and product.
module cla_mul_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int CNT_W = clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q_reg;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] p_reg;

    logic               last_step;
    logic               add_sub;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               ovr;
    logic               shift_in;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign add_b     = q_reg[0] ? m_reg : '0;

`ifdef CLA_MUL_SIGNED_EN
    // The multiplier's sign bit carries negative weight, so the last partial product is subtracted.
    logic unused_cout;
    assign unused_cout = cout;
    assign add_sub     = last_step & q_reg[0];
    assign shift_in    = sum[WIDTH-1] ^ ovr;
`else
    logic unused_ovr;
    assign unused_ovr = ovr;
    assign add_sub    = 1'b0;
    assign shift_in   = cout;
`endif

    cla_addsub #(.WIDTH(WIDTH)) u_addsub (
        .AddSub (add_sub),
        .A      (acc),
        .B      (add_b),
        .R      (sum),
        .Cout   (cout),
        .OVR    (ovr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath registers freeze on flush; the product register only changes on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            acc   <= '0;
            q_reg <= '0;
            cnt   <= '0;
            p_reg <= '0;
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                m_reg <= in_a;
                q_reg <= in_b;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc   <= {shift_in, sum[WIDTH-1:1]};
                q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                cnt   <= cnt + 1'b1;
                if (last_step) begin
                    p_reg <= {shift_in, sum[WIDTH-1:1], sum[0], q_reg[WIDTH-1:1]};
                end
            end
        end
    end

    assign out_p = p_reg;

endmodule
